wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Merges two pipe results and a queued long-latency (LU) result onto two
// registered write ports. Pipe results always win. The LU result waits in a
// 2-entry FIFO until a port is free, or is dropped when a younger pipe write
// targets the same register.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int LU_DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid_i,
  input  logic [4:0]  p0_rd_i,
  input  logic [63:0] p0_value_i,
  input  logic        p1_valid_i,
  input  logic [4:0]  p1_rd_i,
  input  logic [63:0] p1_value_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [63:0] lu_value_i,
  output logic        lu_ready_o,
  output logic        wp0_en_o,
  output logic [4:0]  wp0_addr_o,
  output logic [63:0] wp0_data_o,
  output logic        wp1_en_o,
  output logic [4:0]  wp1_addr_o,
  output logic [63:0] wp1_data_o,
  output logic        stall_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // LU queue: entry 0 is always the head.
  logic [1:0]    count_reg;
  logic [4:0]    q_rd_reg  [2];
  logic [63:0]   q_val_reg [2];
  logic [SW-1:0] starve_reg;

  logic          p0_eff, p1_eff;
  logic          head_valid, head_kill, pop, push;
  logic          en0_next, en1_next;
  logic [4:0]    addr0_next, addr1_next;
  logic [63:0]   data0_next, data1_next;
  logic [1:0]    count_next;
  logic [SW-1:0] starve_next;

  // The queue only accepts while it has room; a pop in the same cycle does not help.
  assign lu_ready_o = (count_reg < 2'(LU_DEPTH));
  assign stall_o    = (starve_reg == SW'(STARVE_LIMIT));
  assign push       = lu_valid_i && lu_ready_o;

  assign p1_eff     = p1_valid_i && (p1_rd_i != 5'd0);
  assign p0_eff     = p0_valid_i && (p0_rd_i != 5'd0) && !(p1_eff && (p1_rd_i == p0_rd_i));
  assign head_valid = (count_reg != 2'd0);
  // A head aimed at r0, or overwritten by a younger pipe write, is simply discarded.
  assign head_kill  = head_valid &&
                      ((q_rd_reg[0] == 5'd0) ||
                       (p0_eff && (q_rd_reg[0] == p0_rd_i)) ||
                       (p1_eff && (q_rd_reg[0] == p1_rd_i)));

  // Port assignment: pipe results fill lowest ports first, head takes what is left.
  always_comb begin
    en0_next   = 1'b0;
    addr0_next = wp0_addr_o;
    data0_next = wp0_data_o;
    en1_next   = 1'b0;
    addr1_next = wp1_addr_o;
    data1_next = wp1_data_o;
    pop        = 1'b0;
    if (p0_eff) begin
      en0_next   = 1'b1;
      addr0_next = p0_rd_i;
      data0_next = p0_value_i;
    end
    if (p1_eff) begin
      if (p0_eff) begin
        en1_next   = 1'b1;
        addr1_next = p1_rd_i;
        data1_next = p1_value_i;
      end else begin
        en0_next   = 1'b1;
        addr0_next = p1_rd_i;
        data0_next = p1_value_i;
      end
    end
    if (head_kill) begin
      pop = 1'b1;
    end else if (head_valid) begin
      if (!en0_next) begin
        en0_next   = 1'b1;
        addr0_next = q_rd_reg[0];
        data0_next = q_val_reg[0];
        pop        = 1'b1;
      end else if (!en1_next) begin
        en1_next   = 1'b1;
        addr1_next = q_rd_reg[0];
        data1_next = q_val_reg[0];
        pop        = 1'b1;
      end
    end
  end

  // Occupancy and starvation bookkeeping.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 2'd1;
    else if (pop && !push) count_next = count_reg - 2'd1;
    starve_next = starve_reg;
    if (!head_valid || pop)                     starve_next = '0;
    else if (starve_reg != SW'(STARVE_LIMIT))   starve_next = starve_reg + SW'(1);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      starve_reg <= '0;
      wp0_en_o   <= 1'b0;
      wp0_addr_o <= 5'd0;
      wp0_data_o <= 64'd0;
      wp1_en_o   <= 1'b0;
      wp1_addr_o <= 5'd0;
      wp1_data_o <= 64'd0;
    end else begin
      count_reg  <= count_next;
      starve_reg <= starve_next;
      wp0_en_o   <= en0_next;
      wp0_addr_o <= addr0_next;
      wp0_data_o <= data0_next;
      wp1_en_o   <= en1_next;
      wp1_addr_o <= addr1_next;
      wp1_data_o <= data1_next;
    end
  end

  // Queue storage: shift on pop, new entry lands behind the surviving entries.
  always_ff @(posedge clk) begin
    if (pop) begin
      q_rd_reg[0]  <= q_rd_reg[1];
      q_val_reg[0] <= q_val_reg[1];
    end
    if (push) begin
      if ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop)) begin
        q_rd_reg[0]  <= lu_rd_i;
        q_val_reg[0] <= lu_value_i;
      end else begin
        q_rd_reg[1]  <= lu_rd_i;
        q_val_reg[1] <= lu_value_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid, lu_valid;
  logic [4:0]  p0_rd, p1_rd, lu_rd;
  logic [63:0] p0_value, p1_value, lu_value;
  logic        lu_ready, wp0_en, wp1_en, stall;
  logic [4:0]  wp0_addr, wp1_addr;
  logic [63:0] wp0_data, wp1_data;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_en   [2];
  logic [4:0]  m_addr [2];
  logic [63:0] m_data [2];

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .LU_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid_i(p0_valid), .p0_rd_i(p0_rd), .p0_value_i(p0_value),
    .p1_valid_i(p1_valid), .p1_rd_i(p1_rd), .p1_value_i(p1_value),
    .lu_valid_i(lu_valid), .lu_rd_i(lu_rd), .lu_value_i(lu_value),
    .lu_ready_o(lu_ready),
    .wp0_en_o(wp0_en), .wp0_addr_o(wp0_addr), .wp0_data_o(wp0_data),
    .wp1_en_o(wp1_en), .wp1_addr_o(wp1_addr), .wp1_data_o(wp1_data),
    .stall_o(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 1'b0; m_addr[i] = 5'd0; m_data[i] = 64'd0;
    end
  endtask

  // One clock of the reference behaviour, computed from the current inputs.
  task automatic model_step();
    ent_t list[$];
    ent_t e;
    bit   p0e, p1e, popped, do_push;
    p1e = p1_valid && (p1_rd != 0);
    p0e = p0_valid && (p0_rd != 0) && !(p1e && (p1_rd == p0_rd));
    do_push = lu_valid && (mq.size() < 2);
    popped = 0;
    if (p0e) begin e.rd = p0_rd; e.val = p0_value; list.push_back(e); end
    if (p1e) begin e.rd = p1_rd; e.val = p1_value; list.push_back(e); end
    if (mq.size() > 0) begin
      if (mq[0].rd == 0 || (p0e && mq[0].rd == p0_rd) || (p1e && mq[0].rd == p1_rd))
        popped = 1;
      else if (list.size() < 2) begin
        list.push_back(mq[0]);
        popped = 1;
      end
    end
    if (mq.size() == 0 || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (popped) void'(mq.pop_front());
    if (do_push) begin e.rd = lu_rd; e.val = lu_value; mq.push_back(e); end
    for (int i = 0; i < 2; i++) begin
      if (i < list.size()) begin
        m_en[i] = 1'b1; m_addr[i] = list[i].rd; m_data[i] = list[i].val;
      end else begin
        m_en[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wp0_en"},   wp0_en,   m_en[0]);
    chk({tag, ".wp0_addr"}, wp0_addr, m_addr[0]);
    chk({tag, ".wp0_data"}, wp0_data, m_data[0]);
    chk({tag, ".wp1_en"},   wp1_en,   m_en[1]);
    chk({tag, ".wp1_addr"}, wp1_addr, m_addr[1]);
    chk({tag, ".wp1_data"}, wp1_data, m_data[1]);
    chk({tag, ".lu_ready"}, lu_ready, (mq.size() < 2));
    chk({tag, ".stall"},    stall,    (m_starve == LIMIT));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    $display("[TB] %s: wp0=%b/%0d/%h wp1=%b/%0d/%h ready=%b stall=%b",
             tag, wp0_en, wp0_addr, wp0_data, wp1_en, wp1_addr, wp1_data, lu_ready, stall);
  endtask

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [63:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [63:0] d1,
                       input bit lv, input logic [4:0] lr, input logic [63:0] ld);
    p0_valid = v0; p0_rd = r0; p0_value = d0;
    p1_valid = v1; p1_rd = r1; p1_value = d1;
    lu_valid = lv; lu_rd = lr; lu_value = ld;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two distinct pipe results land on both ports one cycle later.
    drive(1, 5, 64'hA, 1, 6, 64'hB, 0, 0, 0);
    step("dual_pipe");
    chk("dual_pipe.addr0_const", wp0_addr, 5);
    chk("dual_pipe.data1_const", wp1_data, 64'hB);

    // Same destination: younger p1 wins, only port 0 used.
    drive(1, 7, 64'h1, 1, 7, 64'h2, 0, 0, 0);
    step("same_rd");
    chk("same_rd.data0_const", wp0_data, 64'h2);
    chk("same_rd.en1_const", wp1_en, 1'b0);

    // LU pushes X then Y while both pipes are busy; head starves until stall.
    drive(1, 1, 64'h11, 1, 2, 64'h22, 1, 9, 64'hAAAA_0000_0000_0009);
    step("lu_push_x");
    drive(1, 3, 64'h33, 1, 4, 64'h44, 1, 10, 64'hBBBB_0000_0000_000A);
    step("lu_push_y");
    chk("lu_full.ready_const", lu_ready, 1'b0);
    drive(1, 1, 64'h55, 1, 2, 64'h66, 1, 11, 64'hCC);
    step("blocked_2");
    drive(1, 3, 64'h77, 1, 4, 64'h88, 0, 0, 0);
    step("blocked_3");
    chk("starve.stall_const", stall, 1'b1);
    drive(1, 1, 64'h99, 0, 0, 0, 0, 0, 0);
    step("drain_x");
    chk("drain_x.addr1_const", wp1_addr, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("drain_y");
    chk("drain_y.ready_const", lu_ready, 1'b1);

    // Head overwritten by a pipe write to the same register.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 64'hDEAD);
    step("push_rd9");
    drive(1, 9, 64'h5, 0, 0, 0, 0, 0, 0);
    step("kill_rd9");
    chk("kill_rd9.en1_const", wp1_en, 1'b0);
    chk("kill_rd9.data0_const", wp0_data, 64'h5);

    // p0 targets r0, so head takes port 0.
    drive(0, 0, 0, 0, 0, 0, 1, 3, 64'hBEEF);
    step("push_rd3");
    drive(1, 0, 64'h123, 0, 0, 0, 0, 0, 0);
    step("head_port0");
    chk("head_port0.data0_const", wp0_data, 64'hBEEF);

    // Fill queue, reach stall, then reset mid-cycle.
    drive(1, 1, 64'h1, 1, 2, 64'h2, 1, 12, 64'hF00D);
    step("fill_a");
    drive(1, 1, 64'h1, 1, 2, 64'h2, 1, 13, 64'hF00E);
    step("fill_b");
    drive(1, 1, 64'h1, 1, 2, 64'h2, 0, 0, 0);
    step("fill_c");
    step("fill_d");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_1");
    step("post_reset_2");

    // Random traffic; upstream honours stall by idling p1.
    for (int n = 0; n < 400; n++) begin
      p0_valid = ($urandom_range(0, 3) != 0);
      p0_rd    = 5'($urandom_range(0, 7));
      p0_value = {$urandom, $urandom};
      p1_valid = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      p1_rd    = 5'($urandom_range(0, 7));
      p1_value = {$urandom, $urandom};
      lu_valid = ($urandom_range(0, 1) != 0);
      lu_rd    = 5'($urandom_range(0, 7));
      lu_value = {$urandom, $urandom};
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
